spi_move_tx: RTL and testbench
==============================

# spi_move_tx

SPI slave transmitter that returns the FPGA player's move and the game status to the Arduino over MISO. It is the outbound counterpart of the SPI move receiver and shares its `sck`/`ss` lines. It oversamples the master's SPI clock in the `clk` domain. Game logic posts a move with a one-cycle `send` strobe. The block formats one status byte and shifts it out MSB-first in SPI mode 0 on the next frame the master opens.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on `sck` and `ss` before edge detection; must be ≥ 2.
- `clk` in 1: system clock, the only clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sck` in 1: SPI clock from the master, asynchronous; idle low (mode 0).
- `ss` in 1: SPI slave select, asynchronous, active low.
- `miso` out 1: serial data to the master.
- `send` in 1: one-cycle strobe that captures `move`, `player` and `game_state` into the pending register.
- `move` in 3: column played, 0–6.
- `player` in 1: player who made the move (0 = FPGA, 1 = Arduino).
- `game_state` in 2: 00 running, 01 player 1 won, 10 player 2 won, 11 game over / draw.
- `pending` out 1: a posted byte is waiting and has not yet been fully transmitted.
- `busy` out 1: a frame is in progress (state SHIFT).
- `tx_done` out 1: one-cycle pulse when a frame completes.
- `overrun` out 1: one-cycle pulse when `send` overwrites a pending byte that was never transmitted.

## Operation
- **Byte format** (bit 7 first):
  - bit 7: valid
  - bits 6:5: `game_state`
  - bit 4: `player`
  - bit 3: parity
  - bits 2:0: `move`
- **Parity:** even parity over bits 7:4 and 2:0, so the total number of ones in the byte is even.
- **Idle byte:** if no byte is pending when a frame opens, the block sends 0x00 (valid = 0).
- **Synchronizers:** `sck` and `ss` pass through `SYNC_STAGES` flops, then one more flop for edge detection.
- **State IDLE:**
  - `miso` = 0 and `busy` = 0.
  - On a detected `ss` falling edge: copy the pending byte (or 0x00) into the shift register, set `taken` = `pending`, drive bit 7 on `miso`, clear the bit counter, and go to SHIFT.
- **State SHIFT:**
  - Each detected `sck` rising edge increments the bit counter (3 bits plus a terminal flag).
  - Each detected `sck` falling edge shifts left, so `miso` presents the next bit.
  - After the 8th rising edge, go to DONE.
- **State DONE:**
  - Pulse `tx_done` for one cycle.
  - If `taken` = 1, clear `pending`.
  - Go to IDLE and hold `miso` = 0.
- **Abort:** if `ss` rises during SHIFT before the 8th rising edge, go to IDLE. There is no `tx_done` pulse, `pending` is retained, and the byte is resent in full on the next frame.
- **`send` handling:**
  - `send` always loads the pending register and sets `pending` = 1.
  - `send` clears `taken`, so data posted during a frame is not dropped when that frame completes.
  - `overrun` pulses when `send` arrives while `pending` = 1 and `taken` = 0.
  - A `send` during SHIFT with `taken` = 1 does not pulse `overrun`.
- **Simultaneous events:**
  - `send` in the same cycle as the `ss` fall: the frame carries the previous contents, and the new data stays pending.
  - `send` in the same cycle as DONE: the new data survives and `pending` stays 1.
- **Extra clocks:** `sck` edges while in IDLE or DONE are ignored. Rising edges beyond the 8th within one `ss` window are ignored, and `miso` = 0 after DONE.

## Timing
- **Reset values:** `miso` 0, `pending` 0, `busy` 0, `tx_done` 0, `overrun` 0; state IDLE, `taken` 0, shift register 0x00.
- **Edge latency:** a pin edge on `sck` or `ss` is acted on at most `SYNC_STAGES` + 2 `clk` cycles later.
- **Frame start:** `miso` carries bit 7 at most `SYNC_STAGES` + 2 cycles after the `ss` pin falls. The master must wait at least that long before the first `sck` rise.
- **Constraint:** sck high and low phases must each be ≥ `SYNC_STAGES` + 3 `clk` periods (sck ≤ clk/10 with defaults).
- **Bit updates:** `miso` changes only at the edge following a detected `sck` fall or frame start, never near a master sampling edge.
- **Frame completion:** `tx_done` occurs 1 cycle after the 8th `sck` rise is detected.
- **Reset mid-frame:** `rst` during a frame returns the block to reset values immediately, and the remainder of the master's frame reads 0.

## Configuration
- `SPI_TX_PARITY_EN` defined: bit 3 carries the even parity bit.
- Not defined: bit 3 is constant 0 and no parity logic is built.

## Test plan
- **Basic frame:** reset, then `send` with `move`=5, `player`=1, `game_state`=00, then one 8-bit frame → master reads 0x95; `tx_done` pulses once; `pending` falls to 0.
- **Parity bit:** `send` with `move`=6, `player`=1, `game_state`=10 → reads 0xDE with the macro defined, 0xD6 without it.
- **Idle frame:** frame with nothing pending → reads 0x00; `tx_done` pulses; `overrun` stays 0.
- **Overrun:** two `send`s (`move` 2, then `move` 4; `player` 0, `state` 00) before any frame → `overrun` pulses on the second; the frame reads 0x84.
- **Abort:** raise `ss` after 4 bits of 0x95 → no `tx_done`; `pending` stays 1; the next full frame reads 0x95.
- **Send mid-frame:** `send` of `move`=1 during a frame transmitting 0x95 → the frame reads 0x95, no `overrun`; `pending` stays 1; the next frame reads 0x81.

Source files
------------

// File: rtl/spi_move_tx_if.sv
// -----------------------------------------------------------------------------
// spi_move_tx_if
//   Bundles the SPI pins and the game-logic posting port of spi_move_tx.
//
//   SPI pins   : sck, ss (active low), miso
//   Posting    : send strobe with move / player / game_state fields
//   Status     : pending, busy, tx_done, overrun
//
//   slave  modport : the transmitter itself
//   master modport : the environment (SPI master + game logic)
// -----------------------------------------------------------------------------
interface spi_move_tx_if;
    logic       sck;
    logic       ss;
    logic       miso;
    logic       send;
    logic [2:0] move;
    logic       player;
    logic [1:0] game_state;
    logic       pending;
    logic       busy;
    logic       tx_done;
    logic       overrun;

    modport slave (
        input  sck, ss, send, move, player, game_state,
        output miso, pending, busy, tx_done, overrun
    );

    modport master (
        output sck, ss, send, move, player, game_state,
        input  miso, pending, busy, tx_done, overrun
    );
endinterface

// File: rtl/spi_move_tx.sv
// -----------------------------------------------------------------------------
// spi_move_tx
//   SPI mode-0 slave transmitter returning the FPGA move and game status.
//   The master's sck/ss are oversampled in the clk domain; one status byte
//   {valid, game_state[1:0], player, parity, move[2:0]} is shifted out MSB
//   first on each frame. With nothing pending, a frame carries 0x00.
//
//   Parameters : SYNC_STAGES (>= 2) synchronizer depth on sck and ss
//   Ports      : clk, rst (synchronous, active high), bus (spi_move_tx_if.slave)
//   Macro      : SPI_TX_PARITY_EN - when defined, bit 3 carries even parity
//                over the other seven bits; otherwise bit 3 is constant 0.
// -----------------------------------------------------------------------------
module spi_move_tx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_move_tx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    // ---------------------------------------------------------------------
    // Synchronizers plus one extra flop for edge detection. ss resets high
    // (its idle level) so leaving reset never fakes a frame-start edge
    // unless the master really holds ss low.
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync, ss_sync;
    logic                   sck_d, ss_d;
    logic                   sck_rise, sck_fall, ss_rise, ss_fall;

    // NOTE: reset is sampled on the clock edge only; rst is not in the
    // sensitivity list, so it cannot act asynchronously.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync <= '0;
            ss_sync  <= '1;
            sck_d    <= 1'b0;
            ss_d     <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            ss_sync  <= {ss_sync[SYNC_STAGES-2:0], bus.ss};
            sck_d    <= sck_sync[SYNC_STAGES-1];
            ss_d     <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sck_rise =  sck_sync[SYNC_STAGES-1] & ~sck_d;
    assign sck_fall = ~sck_sync[SYNC_STAGES-1] &  sck_d;
    assign ss_rise  =  ss_sync[SYNC_STAGES-1]  & ~ss_d;
    assign ss_fall  = ~ss_sync[SYNC_STAGES-1]  &  ss_d;

    // ---------------------------------------------------------------------
    // Byte formatting at post time.
    // ---------------------------------------------------------------------
    logic       parity_bit;
    logic [7:0] send_byte;

`ifdef SPI_TX_PARITY_EN
    // Even parity: the parity bit makes the total number of ones even.
    assign parity_bit = ^{1'b1, bus.game_state, bus.player, bus.move};
`else
    assign parity_bit = 1'b0;
`endif

    assign send_byte = {1'b1, bus.game_state, bus.player, parity_bit, bus.move};

    // ---------------------------------------------------------------------
    // FSM: state register and next-state / control decode.
    // ---------------------------------------------------------------------
    logic [7:0] shift_reg;
    logic [3:0] bit_cnt;      // 3-bit count plus terminal flag
    logic       load_frame, shift_en, cnt_en, frame_done, abort;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block is defaulted first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        load_frame = 1'b0;
        shift_en   = 1'b0;
        cnt_en     = 1'b0;
        frame_done = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (ss_fall) begin
                    load_frame = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // An 8th rise coinciding with ss rising still completes the frame.
                if (sck_rise && bit_cnt == 4'd7) begin
                    cnt_en     = 1'b1;
                    state_next = DONE;
                end else if (ss_rise) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (sck_rise) begin
                    cnt_en     = 1'b1;
                end
                shift_en = sck_fall;
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: shift register, bit counter, pending/taken bookkeeping.
    // `taken` marks that the running frame carries the pending byte, so
    // only that byte is retired at DONE. A later `send` clears it, and the
    // send assignments come last so they win over frame start and DONE.
    // ---------------------------------------------------------------------
    logic [7:0] pend_byte;
    logic       pending_q, taken, overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= 8'h00;
            bit_cnt   <= 4'd0;
            pend_byte <= 8'h00;
            pending_q <= 1'b0;
            taken     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= bus.send & pending_q & ~taken;
            if (load_frame) begin
                shift_reg <= pending_q ? pend_byte : 8'h00;
                taken     <= pending_q;
                bit_cnt   <= 4'd0;
            end
            if (shift_en)   shift_reg <= {shift_reg[6:0], 1'b0};
            if (cnt_en)     bit_cnt   <= bit_cnt + 4'd1;
            if (abort)      taken     <= 1'b0;
            if (frame_done) begin
                if (taken) pending_q <= 1'b0;
                taken <= 1'b0;
            end
            if (bus.send) begin
                pend_byte <= send_byte;
                pending_q <= 1'b1;
                taken     <= 1'b0;
            end
        end
    end

    assign bus.miso    = (state == SHIFT) ? shift_reg[7] : 1'b0;
    assign bus.busy    = (state == SHIFT);
    assign bus.tx_done = frame_done;
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_spi_move_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_move_tx
//   Directed and randomized bench for spi_move_tx. An SPI master task runs
//   frames of any length (short = abort, 9 = extra clock) with an optional
//   mid-frame post; a byte-level model tracks what each frame must return,
//   the pending flag, and the tx_done / overrun pulse counts.
// -----------------------------------------------------------------------------
module tb_spi_move_tx;

    localparam int SYNC = 2;
    localparam int HALF = SYNC + 4;   // sck phase length in clk cycles

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_move_tx_if bus();

    spi_move_tx #(.SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int ovr_cnt     = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_done) done_cnt++;
            if (bus.overrun) ovr_cnt++;
        end
    end

    // Reference model state
    bit         m_pending = 1'b0;
    logic [7:0] m_byte    = 8'h00;
    int         m_done    = 0;
    int         m_ovr     = 0;

    function automatic logic [7:0] fmt(input int mv, input int pl, input int gs);
        int b;
        b = 128 + gs * 32 + pl * 16 + mv;
`ifdef SPI_TX_PARITY_EN
        if (($countones(b) % 2) != 0) b = b + 8;
`endif
        return b[7:0];
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_send(input int mv, input int pl, input int gs);
        bus.send       = 1'b1;
        bus.move       = mv[2:0];
        bus.player     = pl[0];
        bus.game_state = gs[1:0];
        @(negedge clk);
        bus.send = 1'b0;
    endtask

    // Post while idle: overruns when an untransmitted byte is overwritten.
    task automatic post(input int mv, input int pl, input int gs);
        @(negedge clk);
        if (m_pending) m_ovr++;
        m_pending = 1'b1;
        m_byte    = fmt(mv, pl, gs);
        pulse_send(mv, pl, gs);
        repeat (2) @(negedge clk);
        check("post_overrun", ovr_cnt, m_ovr);
        check("post_pending", bus.pending, 1);
    endtask

    // Master frame of nbits bits; mid_at >= 0 posts a byte before that bit.
    task automatic frame(input int nbits, input int mid_at, input int mv,
                         input int pl, input int gs, output int rd);
        rd = 0;
        @(negedge clk);
        bus.ss = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == mid_at) pulse_send(mv, pl, gs);
            if (i == 0) check("busy", bus.busy, 1);
            rd = (rd << 1) | int'(bus.miso);
            bus.sck = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.sck = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        bus.ss = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input int nbits, input int mid_at,
                             input int mv, input int pl, input int gs, output int rd);
        int exp_byte, exp_rd;
        exp_byte = m_pending ? int'(m_byte) : 0;
        exp_rd   = (nbits <= 8) ? (exp_byte >> (8 - nbits)) : (exp_byte << (nbits - 8));
        frame(nbits, mid_at, mv, pl, gs, rd);
        if (nbits >= 8) m_done++;
        if (mid_at >= 0 && mid_at < nbits) begin
            m_pending = 1'b1;
            m_byte    = fmt(mv, pl, gs);
        end else if (nbits >= 8) begin
            m_pending = 1'b0;
        end
        check({tag, "_data"},    rd, exp_rd);
        check({tag, "_done"},    done_cnt, m_done);
        check({tag, "_overrun"}, ovr_cnt, m_ovr);
        check({tag, "_pending"}, bus.pending, int'(m_pending));
        check({tag, "_miso"},    bus.miso, 0);
    endtask

    initial begin
        int rd;
        int nb, mid, mv, pl, gs, ns;

        rst            = 1'b1;
        bus.sck        = 1'b0;
        bus.ss         = 1'b1;
        bus.send       = 1'b0;
        bus.move       = 3'd0;
        bus.player     = 1'b0;
        bus.game_state = 2'd0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_miso",    bus.miso, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_busy",    bus.busy, 0);
        check("rst_tx_done", bus.tx_done, 0);
        check("rst_overrun", bus.overrun, 0);

        // Basic frame
        post(5, 1, 0);
        run_frame("basic", 8, -1, 0, 0, 0, rd);
        check("basic_lit", rd, 'h95);

        // Parity bit
        post(6, 1, 2);
        run_frame("parity", 8, -1, 0, 0, 0, rd);
`ifdef SPI_TX_PARITY_EN
        check("parity_lit", rd, 'hDE);
`else
        check("parity_lit", rd, 'hD6);
`endif

        // Idle frame
        run_frame("idle", 8, -1, 0, 0, 0, rd);
        check("idle_lit", rd, 'h00);

        // Overrun
        post(2, 0, 0);
        post(4, 0, 0);
        check("overrun_pulses", ovr_cnt, 1);
        run_frame("overrun", 8, -1, 0, 0, 0, rd);
        check("overrun_lit", rd, 'h84);

        // Abort after 4 bits, then full resend
        post(5, 1, 0);
        run_frame("abort", 4, -1, 0, 0, 0, rd);
        check("abort_lit", rd, 'h9);
        run_frame("resend", 8, -1, 0, 0, 0, rd);
        check("resend_lit", rd, 'h95);

        // Send mid-frame
        post(5, 1, 0);
        run_frame("mid", 8, 3, 1, 0, 0, rd);
        check("mid_lit", rd, 'h95);
        run_frame("after_mid", 8, -1, 0, 0, 0, rd);
        check("after_mid_lit", rd, 'h81);

        // Extra sck rise: ninth bit reads 0, single tx_done
        post(3, 0, 1);
        run_frame("extra", 9, -1, 0, 0, 0, rd);

        // Reset mid-frame: remainder of the frame reads 0, pending cleared
        post(6, 0, 3);
        @(negedge clk);
        bus.ss = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.sck = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.sck = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_pending = 1'b0;
        repeat (HALF) @(negedge clk);
        rd = 0;
        for (int i = 0; i < 5; i++) begin
            rd = (rd << 1) | int'(bus.miso);
            bus.sck = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.sck = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        bus.ss = 1'b1;
        repeat (HALF) @(negedge clk);
        check("rstmid_data",    rd, 0);
        check("rstmid_pending", bus.pending, 0);
        check("rstmid_done",    done_cnt, m_done);

        // Randomized traffic against the model
        for (int k = 0; k < 24; k++) begin
            ns = $urandom_range(0, 2);
            for (int j = 0; j < ns; j++)
                post($urandom_range(0, 6), $urandom_range(0, 1), $urandom_range(0, 3));
            nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            mid = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
            mv  = $urandom_range(0, 6);
            pl  = $urandom_range(0, 1);
            gs  = $urandom_range(0, 3);
            run_frame("rand", nb, mid, mv, pl, gs, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
